conv_stream_loader: RTL and testbench

- Parametrised front-end for the conv accelerator. Accepts the serial host byte stream (mode, din, ram_en) and generates write strobes and addresses for the feature-data RAM and the weight RAM.
- Tracks load completion and issues a one-cycle start pulse to the compute core. Waits for the core to finish and reports errors for malformed streams.
- Generalises the fixed 64-byte data / 54-byte weight load to configurable depths and input-channel count, and adds handshake and error reporting.

---
 rtl/conv_stream_loader.sv | 120 ++++++++++++
 tb/tb_conv_stream_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_loader.sv
// Host byte-stream front-end for the conv accelerator: routes feature/weight
// elements to their RAM write ports, starts the core and waits for it to finish.
module conv_stream_loader #(
  parameter int DATA_W    = 8,
  parameter int IMG_H     = 8,
  parameter int IMG_W     = 8,
  parameter int IN_CH     = 1,
  parameter int WGT_DEPTH = 54,
  parameter int DADDR_W   = 6,
  parameter int WADDR_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ram_en,
  input  logic               mode,
  input  logic [DATA_W-1:0]  din,
  output logic               data_we,
  output logic [DADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0]  data_wdata,
  output logic               wgt_we,
  output logic [WADDR_W-1:0] wgt_addr,
  output logic [DATA_W-1:0]  wgt_wdata,
  output logic               core_start,
  input  logic               core_done,
  output logic               busy,
  output logic               err
);

  localparam int DATA_DEPTH = IMG_H * IMG_W * IN_CH;
  localparam logic [DADDR_W-1:0] DLAST = DADDR_W'(DATA_DEPTH - 1);
  localparam logic [WADDR_W-1:0] WLAST = WADDR_W'(WGT_DEPTH - 1);

  typedef enum logic [1:0] {LOAD_DATA, LOAD_WGT, START, WAIT_CORE} state_t;

  state_t state, state_nxt;
  logic [DADDR_W-1:0] dcnt;
  logic [WADDR_W-1:0] wcnt;
  logic d_acc, w_acc, bad, d_last, w_last;
  logic start_d, busy_d;

  // Classify the current stream element against the load phase.
  always_comb begin
    d_acc = 1'b0;
    w_acc = 1'b0;
    bad   = 1'b0;
    case (state)
      LOAD_DATA: begin
        d_acc = ram_en & ~mode;
        bad   = ram_en & mode;
      end
      LOAD_WGT: begin
        w_acc = ram_en & mode;
        bad   = ram_en & ~mode;
      end
      default: bad = ram_en;
    endcase
  end

  assign d_last = d_acc && (dcnt == DLAST);
  assign w_last = w_acc && (wcnt == WLAST);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_DATA;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_DATA: if (d_last) state_nxt = LOAD_WGT;
      LOAD_WGT:  if (w_last) state_nxt = START;
      START:     state_nxt = WAIT_CORE;
      WAIT_CORE: if (core_done) state_nxt = LOAD_DATA;
      default:   state_nxt = LOAD_DATA;
    endcase
  end

  // Handshake outputs are registered, so core_start lands the cycle after the last weight write.
  always_comb begin
    start_d = (state == START);
    busy_d  = (state == START) || ((state == WAIT_CORE) && !core_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt       <= '0;
      wcnt       <= '0;
      data_we    <= 1'b0;
      data_addr  <= '0;
      data_wdata <= '0;
      wgt_we     <= 1'b0;
      wgt_addr   <= '0;
      wgt_wdata  <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_we    <= d_acc;
      wgt_we     <= w_acc;
      core_start <= start_d;
      busy       <= busy_d;
      err        <= err | bad;
      if (d_acc) begin
        data_addr  <= dcnt;
        data_wdata <= din;
        dcnt       <= d_last ? '0 : dcnt + DADDR_W'(1);
      end
      if (w_acc) begin
        wgt_addr  <= wcnt;
        wgt_wdata <= din;
        wcnt      <= w_last ? '0 : wcnt + WADDR_W'(1);
      end
      if (state == WAIT_CORE && core_done) begin
        dcnt <= '0;
        wcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_loader.sv
// Directed bench for conv_stream_loader: default geometry plus a small 4x4x2 / 36-weight instance.
module tb_conv_stream_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       ram_en, mode, core_done;
  logic [7:0] din;
  logic       data_we, wgt_we, core_start, busy, err;
  logic [5:0] data_addr, wgt_addr;
  logic [7:0] data_wdata, wgt_wdata;

  logic       s_ram_en, s_mode, s_core_done;
  logic [7:0] s_din;
  logic       s_data_we, s_wgt_we, s_core_start, s_busy, s_err;
  logic [5:0] s_data_addr, s_wgt_addr;
  logic [7:0] s_data_wdata, s_wgt_wdata;

  int errors = 0;
  int checks = 0;

  conv_stream_loader dut (
    .clk(clk), .rst(rst), .ram_en(ram_en), .mode(mode), .din(din),
    .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_wdata(wgt_wdata),
    .core_start(core_start), .core_done(core_done), .busy(busy), .err(err)
  );

  conv_stream_loader #(.IMG_H(4), .IMG_W(4), .IN_CH(2), .WGT_DEPTH(36)) u_sw (
    .clk(clk), .rst(rst), .ram_en(s_ram_en), .mode(s_mode), .din(s_din),
    .data_we(s_data_we), .data_addr(s_data_addr), .data_wdata(s_data_wdata),
    .wgt_we(s_wgt_we), .wgt_addr(s_wgt_addr), .wgt_wdata(s_wgt_wdata),
    .core_start(s_core_start), .core_done(s_core_done), .busy(s_busy), .err(s_err)
  );

  function automatic logic [7:0] dval(input int i);
    return 8'(i * 3 + 1);
  endfunction

  function automatic logic [7:0] wval(input int i);
    return 8'(i * 7 + 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left at a falling edge; outputs are sampled there.
  task automatic idle();
    @(negedge clk);
  endtask

  task automatic push(input logic m, input logic [7:0] d);
    ram_en = 1'b1; mode = m; din = d;
    @(negedge clk);
    ram_en = 1'b0;
  endtask

  task automatic s_push(input logic m, input logic [7:0] d);
    s_ram_en = 1'b1; s_mode = m; s_din = d;
    @(negedge clk);
    s_ram_en = 1'b0;
  endtask

  task automatic load_data(input int from, input int to, input bit gap);
    for (int i = from; i < to; i++) begin
      push(1'b0, dval(i));
      chk("d_we", data_we, 1);
      chk("d_addr", data_addr, i);
      chk("d_wdata", data_wdata, dval(i));
      chk("d_no_wgt_we", wgt_we, 0);
      if (gap) begin
        idle();
        chk("d_gap_we", data_we, 0);
      end
    end
  endtask

  // Loads every weight, then checks core_start one cycle after the last write.
  task automatic load_wgt(input bit gap);
    for (int j = 0; j < 54; j++) begin
      push(1'b1, wval(j));
      chk("w_we", wgt_we, 1);
      chk("w_addr", wgt_addr, j);
      chk("w_wdata", wgt_wdata, wval(j));
      chk("w_no_data_we", data_we, 0);
      if (j == 53) chk("start_early", core_start, 0);
      else if (gap) begin
        idle();
        chk("w_gap_we", wgt_we, 0);
        chk("w_gap_start", core_start, 0);
      end
    end
    idle();
    chk("start_pulse", core_start, 1);
    chk("start_busy", busy, 1);
    chk("w_we_drop", wgt_we, 0);
    idle();
    chk("start_one_cycle", core_start, 0);
    chk("busy_hold", busy, 1);
  endtask

  task automatic finish_core();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("busy_release", busy, 0);
  endtask

  initial begin
    int nbusy;
    rst = 1'b1; ram_en = 1'b0; mode = 1'b0; din = '0; core_done = 1'b0;
    s_ram_en = 1'b0; s_mode = 1'b0; s_din = '0; s_core_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_outs", {data_we, wgt_we, core_start, busy, err}, 0);
    chk("rst_addrs", {data_addr, wgt_addr}, 0);
    chk("rst_wdata", {data_wdata, wgt_wdata}, 0);
    chk("rst_sw_outs", {s_data_we, s_wgt_we, s_core_start, s_busy, s_err}, 0);

    // Continuous load, then a long core run
    load_data(0, 64, 1'b0);
    load_wgt(1'b0);
    nbusy = 0;
    for (int k = 0; k < 200; k++) begin
      idle();
      if (busy !== 1'b1 || core_start !== 1'b0) nbusy++;
    end
    chk("busy_200", nbusy, 0);
    finish_core();
    chk("err_clean", err, 0);

    // Stray core_done while loading is ignored
    load_data(0, 3, 1'b0);
    core_done = 1'b1;
    idle();
    core_done = 1'b0;
    chk("stray_done_err", err, 0);
    chk("stray_done_busy", busy, 0);

    // Gapped load continues from address 3
    load_data(3, 64, 1'b1);
    load_wgt(1'b1);
    finish_core();
    chk("gap_err", err, 0);

    // Early weight element is dropped and flagged
    load_data(0, 10, 1'b0);
    push(1'b1, 8'hEE);
    chk("early_wgt_we", wgt_we, 0);
    chk("early_data_we", data_we, 0);
    chk("early_err", err, 1);
    load_data(10, 64, 1'b0);
    load_wgt(1'b0);
    finish_core();
    chk("err_sticky", err, 1);

    // Reset mid-load with an element presented in the reset cycle
    load_data(0, 30, 1'b0);
    rst = 1'b1; ram_en = 1'b1; mode = 1'b0; din = 8'h55;
    @(negedge clk);
    rst = 1'b0; ram_en = 1'b0;
    chk("mid_rst_outs", {data_we, wgt_we, core_start, busy, err}, 0);
    chk("mid_rst_addr", data_addr, 0);
    chk("mid_rst_wdata", data_wdata, 0);
    load_data(0, 64, 1'b0);
    load_wgt(1'b0);
    finish_core();

    // Small-geometry instance: 32 data, 36 weights
    for (int i = 0; i < 32; i++) begin
      s_push(1'b0, dval(i));
      chk("s_d_we", s_data_we, 1);
      chk("s_d_addr", s_data_addr, i);
    end
    for (int j = 0; j < 36; j++) begin
      s_push(1'b1, wval(j));
      chk("s_w_we", s_wgt_we, 1);
      chk("s_w_addr", s_wgt_addr, j);
      chk("s_w_wdata", s_wgt_wdata, wval(j));
      if (j == 0) chk("s_d_we_drop", s_data_we, 0);
    end
    chk("s_start_early", s_core_start, 0);
    idle();
    chk("s_start", s_core_start, 1);
    chk("s_busy", s_busy, 1);
    chk("s_err_clean", s_err, 0);
    s_push(1'b0, 8'h11);
    chk("s_wait_err", s_err, 1);
    chk("s_wait_no_dwe", s_data_we, 0);
    s_push(1'b1, 8'h22);
    chk("s_wait_no_wwe", s_wgt_we, 0);
    chk("s_busy_hold", s_busy, 1);
    s_core_done = 1'b1;
    @(negedge clk);
    s_core_done = 1'b0;
    chk("s_busy_release", s_busy, 0);
    s_push(1'b0, 8'h33);
    chk("s_reload_addr", s_data_addr, 0);
    chk("s_reload_we", s_data_we, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
